// File: rtl/aes_key_expand.sv
// ============================================================================
// Module   : aes_key_expand (with aes_sbox)
// Purpose  : Iterative AES-128 key schedule feeding the single-round datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand #(
    parameter int SBOX_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    output logic [3:0]   key_progress,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] rf [0:10];
    logic [127:0] last_key;
    logic [7:0]   rcon;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         step;

    // last_key mirrors the most recently written slot so no read mux is needed.
    assign rot_word = {last_key[103:96], last_key[127:104]};
    assign t_word   = sub_word ^ {24'h0, rcon};
    assign w0n      = last_key[31:0]   ^ t_word;
    assign w1n      = last_key[63:32]  ^ w0n;
    assign w2n      = last_key[95:64]  ^ w1n;
    assign w3n      = last_key[127:96] ^ w2n;

    if (SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 1) begin : g_bad_param
        $error("aes_key_expand: SBOX_PER_CYCLE must be 4 or 1");
    end

    if (SBOX_PER_CYCLE == 4) begin : g_par
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .din  (rot_word[b*8 +: 8]),
                .dout (sub_word[b*8 +: 8])
            );
        end
        assign step = (state == EXPAND);
    end else begin : g_ser
        logic [1:0]  phase;
        logic [23:0] temp;
        logic [7:0]  sb_in;
        logic [7:0]  sb_out;

        assign sb_in = rot_word[{phase, 3'b000} +: 8];

        aes_sbox u_sbox (
            .din  (sb_in),
            .dout (sb_out)
        );

        // Bytes shift in from the top so byte 0 lands in temp[7:0] after three steps.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                phase <= 2'd0;
                temp  <= 24'h0;
            end else if (state == EXPAND) begin
                phase <= phase + 2'd1;
                temp  <= {sb_out, temp[23:8]};
            end
        end

        assign sub_word = {sb_out, temp};
        assign step     = (state == EXPAND) && (phase == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_ready    <= 1'b1;
            busy         <= 1'b0;
            keys_valid   <= 1'b0;
            key_progress <= 4'd0;
            rcon         <= 8'h01;
            last_key     <= 128'h0;
            for (int i = 0; i < 11; i++) rf[i] <= 128'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        rf[0]        <= key_in;
                        last_key     <= key_in;
                        key_progress <= 4'd0;
                        keys_valid   <= 1'b0;
                        rcon         <= 8'h01;
                        key_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (step) begin
                        rf[key_progress + 4'd1] <= {w3n, w2n, w1n, w0n};
                        last_key     <= {w3n, w2n, w1n, w0n};
                        key_progress <= key_progress + 4'd1;
                        rcon         <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        if (key_progress == 4'd9) begin
                            keys_valid <= 1'b1;
                            key_ready  <= 1'b1;
                            busy       <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                default: begin
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_key = 128'h0;
        if (rd_idx <= 4'd10) rd_key = rf[rd_idx];
    end
endmodule

`default_nettype wire
